// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: latches a six-entry code table, then shifts in one bit per cycle and emits symbols 1..6.
// Optional per-symbol histogram counters DCNT1..DCNT6 are built when HUFFMAN_DECODER_HIST_EN is defined.
module huffman_decoder #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [7:0]       HC1,
    input  logic [7:0]       HC2,
    input  logic [7:0]       HC3,
    input  logic [7:0]       HC4,
    input  logic [7:0]       HC5,
    input  logic [7:0]       HC6,
    input  logic [7:0]       M1,
    input  logic [7:0]       M2,
    input  logic [7:0]       M3,
    input  logic [7:0]       M4,
    input  logic [7:0]       M5,
    input  logic [7:0]       M6,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             sym_valid,
    output logic [7:0]       sym_data,
    output logic             dec_err,
    output logic [CNT_W-1:0] sym_total,
    output logic [7:0]       DCNT1,
    output logic [7:0]       DCNT2,
    output logic [7:0]       DCNT3,
    output logic [7:0]       DCNT4,
    output logic [7:0]       DCNT5,
    output logic [7:0]       DCNT6
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [3:0] MAX_LEN_C = 4'(MAX_LEN);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 8; k++) begin
            c = c + {3'd0, v[k]};
        end
        return c;
    endfunction

    state_t           state_r, state_n;
    logic [7:0]       hc_in_s [6];
    logic [7:0]       m_in_s  [6];
    logic [7:0]       hc_r    [6];
    logic [7:0]       m_r     [6];
    logic [3:0]       lc_r    [6];
    logic [7:0]       acc_r, acc_n_s;
    logic [3:0]       len_r, len_n_s;
    logic [5:0]       match_s;
    logic             hit_s;
    logic [7:0]       idx_s;
    logic             load_s, shift_s;
    logic             ready_r, sym_valid_r, dec_err_r;
    logic [7:0]       sym_data_r;
    logic [CNT_W-1:0] sym_total_r;

    assign hc_in_s[0] = HC1;  assign m_in_s[0] = M1;
    assign hc_in_s[1] = HC2;  assign m_in_s[1] = M2;
    assign hc_in_s[2] = HC3;  assign m_in_s[2] = M3;
    assign hc_in_s[3] = HC4;  assign m_in_s[3] = M4;
    assign hc_in_s[4] = HC5;  assign m_in_s[4] = M5;
    assign hc_in_s[5] = HC6;  assign m_in_s[5] = M6;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state: the table is taken once, then frozen until reset.
    always_comb begin
        state_n = state_r;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (code_valid) begin
                    state_n = S_RUN;
                    load_s  = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RUN: begin
                state_n = S_RUN;
                shift_s = bit_valid;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Candidate accumulator and table match; lowest index wins on an illegal table.
    always_comb begin
        acc_n_s = {acc_r[6:0], bit_in};
        len_n_s = len_r + 4'd1;
        match_s = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            match_s[i] = (m_r[i] != 8'h00) && (len_n_s == lc_r[i]) &&
                         ((acc_n_s & m_r[i]) == (hc_r[i] & m_r[i]));
        end
        hit_s = |match_s;
        casez (match_s)
            6'b?????1: idx_s = 8'd1;
            6'b????10: idx_s = 8'd2;
            6'b???100: idx_s = 8'd3;
            6'b??1000: idx_s = 8'd4;
            6'b?10000: idx_s = 8'd5;
            6'b100000: idx_s = 8'd6;
            default:   idx_s = 8'd0;
        endcase
    end

    // Table capture, bit accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                hc_r[i] <= 8'h00;
                m_r[i]  <= 8'h00;
                lc_r[i] <= 4'd0;
            end
            acc_r       <= 8'h00;
            len_r       <= 4'd0;
            ready_r     <= 1'b0;
            sym_valid_r <= 1'b0;
            sym_data_r  <= 8'h00;
            dec_err_r   <= 1'b0;
            sym_total_r <= {CNT_W{1'b0}};
        end else begin
            sym_valid_r <= 1'b0;
            dec_err_r   <= 1'b0;
            ready_r     <= (state_n == S_RUN);
            if (load_s) begin
                for (int i = 0; i < 6; i++) begin
                    hc_r[i] <= hc_in_s[i];
                    m_r[i]  <= m_in_s[i];
                    lc_r[i] <= popcount8(m_in_s[i]);
                end
            end
            if (shift_s) begin
                if (hit_s) begin
                    sym_valid_r <= 1'b1;
                    sym_data_r  <= idx_s;
                    acc_r       <= 8'h00;
                    len_r       <= 4'd0;
                    if (sym_total_r != {CNT_W{1'b1}}) begin
                        sym_total_r <= sym_total_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else if (len_n_s == MAX_LEN_C) begin
                    dec_err_r <= 1'b1;
                    acc_r     <= 8'h00;
                    len_r     <= 4'd0;
                end else begin
                    acc_r <= acc_n_s;
                    len_r <= len_n_s;
                end
            end
        end
    end

    assign bit_ready = ready_r;
    assign sym_valid = sym_valid_r;
    assign sym_data  = sym_data_r;
    assign dec_err   = dec_err_r;
    assign sym_total = sym_total_r;

`ifdef HUFFMAN_DECODER_HIST_EN
    logic [7:0] dcnt_r [6];

    // Per-symbol saturating decode histogram.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) begin
                dcnt_r[i] <= 8'h00;
            end
        end else if (shift_s && hit_s) begin
            for (int i = 0; i < 6; i++) begin
                if ((idx_s == 8'(i + 1)) && (dcnt_r[i] != 8'hFF)) begin
                    dcnt_r[i] <= dcnt_r[i] + 8'd1;
                end
            end
        end
    end

    assign DCNT1 = dcnt_r[0];
    assign DCNT2 = dcnt_r[1];
    assign DCNT3 = dcnt_r[2];
    assign DCNT4 = dcnt_r[3];
    assign DCNT5 = dcnt_r[4];
    assign DCNT6 = dcnt_r[5];
`else
    assign DCNT1 = 8'h00;
    assign DCNT2 = 8'h00;
    assign DCNT3 = 8'h00;
    assign DCNT4 = 8'h00;
    assign DCNT5 = 8'h00;
    assign DCNT6 = 8'h00;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed steps plus random traffic against a codeword-level model.
module tb_huffman_decoder;

    logic        clk = 1'b0;
    logic        reset, code_valid, bit_valid, bit_in;
    logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0]  M1, M2, M3, M4, M5, M6;
    logic        bit_ready, sym_valid, dec_err;
    logic [7:0]  sym_data;
    logic [15:0] sym_total;
    logic [7:0]  DCNT1, DCNT2, DCNT3, DCNT4, DCNT5, DCNT6;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [47:0] STD_HC = {8'h1F, 8'h1E, 8'h0E, 8'h06, 8'h02, 8'h00};
    localparam logic [47:0] STD_M  = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
    localparam logic [47:0] NO6_M  = {8'h00, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    huffman_decoder dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
        .sym_valid(sym_valid), .sym_data(sym_data), .dec_err(dec_err),
        .sym_total(sym_total),
        .DCNT1(DCNT1), .DCNT2(DCNT2), .DCNT3(DCNT3),
        .DCNT4(DCNT4), .DCNT5(DCNT5), .DCNT6(DCNT6)
    );

    always #5 clk = ~clk;

    // Reference model: codewords held as bit strings, pending bits in a queue.
    bit          loaded;
    int          q[$];
    logic [7:0]  t_hc[6];
    logic [7:0]  t_m[6];
    logic        e_ready, e_sv, e_err;
    logic [7:0]  e_sd;
    logic [15:0] e_tot;
    logic [7:0]  e_dcnt[6];

    function automatic bit code_matches(int i);
        int len;
        len = $countones(t_m[i]);
        if (len == 0 || len != q.size()) return 1'b0;
        for (int k = 0; k < len; k++) begin
            if (q[k] != int'(t_hc[i][len-1-k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        int hit;
        if (reset) begin
            loaded = 1'b0;
            q.delete();
            e_ready = 1'b0; e_sv = 1'b0; e_err = 1'b0; e_sd = 8'h00; e_tot = 16'h0000;
            for (int i = 0; i < 6; i++) e_dcnt[i] = 8'h00;
        end else begin
            e_sv  = 1'b0;
            e_err = 1'b0;
            if (!loaded) begin
                if (code_valid) begin
                    t_hc = '{HC1, HC2, HC3, HC4, HC5, HC6};
                    t_m  = '{M1, M2, M3, M4, M5, M6};
                    loaded = 1'b1;
                end
            end else if (bit_valid) begin
                q.push_back(int'(bit_in));
                hit = 0;
                for (int i = 5; i >= 0; i--) begin
                    if (code_matches(i)) hit = i + 1;
                end
                if (hit != 0) begin
                    e_sv = 1'b1;
                    e_sd = 8'(hit);
                    if (e_tot != 16'hFFFF) e_tot = e_tot + 16'd1;
`ifdef HUFFMAN_DECODER_HIST_EN
                    if (e_dcnt[hit-1] != 8'hFF) e_dcnt[hit-1] = e_dcnt[hit-1] + 8'd1;
`endif
                    q.delete();
                end else if (q.size() == 8) begin
                    e_err = 1'b1;
                    q.delete();
                end
            end
            e_ready = loaded;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("bit_ready", 64'(bit_ready), 64'(e_ready));
        chk("sym_valid", 64'(sym_valid), 64'(e_sv));
        chk("sym_data",  64'(sym_data),  64'(e_sd));
        chk("dec_err",   64'(dec_err),   64'(e_err));
        chk("sym_total", 64'(sym_total), 64'(e_tot));
        chk("dcnt", 64'({DCNT6, DCNT5, DCNT4, DCNT3, DCNT2, DCNT1}),
            64'({e_dcnt[5], e_dcnt[4], e_dcnt[3], e_dcnt[2], e_dcnt[1], e_dcnt[0]}));
    endtask

    task automatic cyc(input logic bv, input logic b);
        bit_valid = bv;
        bit_in    = b;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_table(input logic [47:0] h, input logic [47:0] m);
        {HC6, HC5, HC4, HC3, HC2, HC1} = h;
        {M6, M5, M4, M3, M2, M1} = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        code_valid = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic load(input logic [47:0] h, input logic [47:0] m);
        set_table(h, m);
        code_valid = 1'b1;
        cyc(1'b0, 1'b0);
    endtask

    task automatic send_sym(input int s, input int gap);
        int len;
        len = $countones(t_m[s-1]);
        for (int k = len - 1; k >= 0; k--) begin
            cyc(1'b1, t_hc[s-1][k]);
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'($urandom));
        end
    endtask

    initial begin
        reset = 1'b1; code_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        set_table(48'h0, 48'h0);
        do_reset();

        // Bits before any table: ignored, bit_ready low; then load and alter HC1.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        load(STD_HC, STD_M);
        chk("ready_after_load", 64'(bit_ready), 64'd1);
        HC1 = 8'hFF;
        code_valid = 1'b0;
        cyc(1'b1, 1'b0);
        chk("frozen_table_sym1", 64'(sym_data), 64'd1);

        // Back-to-back 0,1,0,1,1,0 -> 1,2,3.
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
        chk("b2b_last_sym", 64'(sym_data), 64'd3);

        // Gapped 11111 and 11110 -> 6 then 5.
        send_sym(6, 3);
        send_sym(5, 3);

        // Reset in the middle of a codeword discards the partial bits.
        cyc(1'b1, 1'b1); cyc(1'b1, 1'b1);
        do_reset();
        chk("reset_total_zero", 64'(sym_total), 64'd0);
        load(STD_HC, STD_M);
        code_valid = 1'b0;
        cyc(1'b1, 1'b0);
        chk("after_reset_sym1", 64'(sym_data), 64'd1);

        // Entry 6 disabled: eight 1s give one dec_err, then 0 decodes as 1.
        do_reset();
        load(STD_HC, NO6_M);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        chk("err_pulse", 64'(dec_err), 64'd1);
        cyc(1'b1, 1'b0);
        chk("after_err_sym1", 64'(sym_data), 64'd1);

        // Random traffic: codewords, junk bits, gaps, ignored table wiggles.
        do_reset();
        load(STD_HC, STD_M);
        for (int n = 0; n < 150; n++) begin
            int s;
            s = int'($urandom_range(1, 8));
            code_valid = 1'($urandom);
            HC1 = 8'($urandom);
            if (s <= 6) send_sym(s, int'($urandom_range(0, 1)));
            else cyc(1'b1, 1'($urandom));
        end

        // Counter saturation: 300 x symbol 1, 4 x symbol 4.
        do_reset();
        load(STD_HC, STD_M);
        code_valid = 1'b0;
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_sym(4, 0);
        chk("total_304", 64'(sym_total), 64'd304);
`ifdef HUFFMAN_DECODER_HIST_EN
        chk("dcnt1_sat", 64'(DCNT1), 64'd255);
        chk("dcnt4", 64'(DCNT4), 64'd4);
`else
        chk("dcnt_tied", 64'({DCNT6, DCNT5, DCNT4, DCNT3, DCNT2, DCNT1}), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
